// File: rtl/sequence_checker.sv
// Checks a 4-bit count stream against the repeating 0,8,5,3,7,2 pattern of the
// upstream T-flip-flop generator; reports mismatches, completed cycles and lock.
module sequence_checker #(
  parameter logic [7:0] SAT_MAX = 8'd255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       valid_in,
  input  logic [3:0] Yt,
  output logic [3:0] expected,
  output logic       locked,
  output logic       error,
  output logic       cycle_done,
  output logic [7:0] err_count,
  output logic [7:0] cycle_count,
  output logic       state_dbg,
  output logic [2:0] idx_dbg
);

  // Handshake: valid_in qualifies Yt for exactly the rising edge it is high on;
  // there is no ready, the checker accepts every valid sample, and with
  // valid_in low every register holds while the two pulses return to 0.

  typedef enum logic {
    SEARCH = 1'b0,
    TRACK  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic       locked_d, error_d, cycle_done_d;
  logic [3:0] expected_d;
  logic       err_inc, cyc_inc;

  function automatic logic [3:0] table_value(input logic [2:0] i);
    logic [3:0] v;
    case (i)
      3'd0:    v = 4'd0;
      3'd1:    v = 4'd8;
      3'd2:    v = 4'd5;
      3'd3:    v = 4'd3;
      3'd4:    v = 4'd7;
      3'd5:    v = 4'd2;
      default: v = 4'd0;
    endcase
    return v;
  endfunction

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    locked_d     = locked;
    error_d      = 1'b0;
    cycle_done_d = 1'b0;
    err_inc      = 1'b0;
    cyc_inc      = 1'b0;
    if (valid_in) begin
      case (state_q)
        SEARCH: begin
          // Unsynchronised: anything but the cycle start is simply ignored.
          if (Yt == 4'd0) begin
            state_d = TRACK;
            idx_d   = 3'd1;
          end
        end
        TRACK: begin
          if (Yt == table_value(idx_q)) begin
            if (idx_q == 3'd5) begin
              idx_d        = 3'd0;
              cycle_done_d = 1'b1;
              cyc_inc      = 1'b1;
              locked_d     = 1'b1;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            error_d  = 1'b1;
            err_inc  = 1'b1;
            locked_d = 1'b0;
            // A mismatching 0 is itself a valid cycle start, so resync at once.
            if (Yt == 4'd0) begin
              state_d = TRACK;
              idx_d   = 3'd1;
            end else begin
              state_d = SEARCH;
              idx_d   = 3'd0;
            end
          end
        end
        default: begin
          state_d = SEARCH;
          idx_d   = 3'd0;
        end
      endcase
    end
    expected_d = (state_d == TRACK) ? table_value(idx_d) : 4'd0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= SEARCH;
      idx_q       <= 3'd0;
      expected    <= 4'd0;
      locked      <= 1'b0;
      error       <= 1'b0;
      cycle_done  <= 1'b0;
      err_count   <= 8'd0;
      cycle_count <= 8'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      expected   <= expected_d;
      locked     <= locked_d;
      error      <= error_d;
      cycle_done <= cycle_done_d;
      if (err_inc && (err_count != SAT_MAX)) err_count <= err_count + 8'd1;
      if (cyc_inc && (cycle_count != SAT_MAX)) cycle_count <= cycle_count + 8'd1;
    end
  end

  assign state_dbg = state_q;
  assign idx_dbg   = idx_q;

endmodule
